// File: rtl/branch_predictor_gshare_pkg.sv
// Shared definitions for the gshare/bimodal branch direction predictor.
// Holds the default parameter values, the weakly-taken counter reset value,
// and the saturating counter helpers used by the pattern history table and
// the statistics counters.
package bp_pkg;

  // Default configuration.
  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_IDX_W  = 6;
  localparam int unsigned DEF_HIST_W = 6;
  localparam int unsigned DEF_CNT_W  = 2;

  // Counters are at most 4 bits wide. The helpers work on this width and
  // callers truncate the result to their own CNT_W.
  localparam int unsigned CNT_MAX_W = 4;

  // Weakly-taken reset value for the default counter width: 2^(CNT_W-1).
  localparam logic [CNT_MAX_W-1:0] CNT_RST_DEF = CNT_MAX_W'(1 << (DEF_CNT_W - 1));

  // Weakly-taken reset value for an arbitrary counter width.
  function automatic logic [CNT_MAX_W-1:0] cnt_rst(input int unsigned cnt_w);
    return CNT_MAX_W'(1 << (cnt_w - 1));
  endfunction

  // One saturating step of a cnt_w-bit counter: up when inc=1 (stops at
  // 2^cnt_w-1), down when inc=0 (stops at 0).
  function automatic logic [CNT_MAX_W-1:0] sat_step(input logic [CNT_MAX_W-1:0] cnt,
                                                    input logic                 inc,
                                                    input int unsigned          cnt_w);
    logic [CNT_MAX_W-1:0] max_v;
    max_v = CNT_MAX_W'((1 << cnt_w) - 1);
    if (inc) begin
      return (cnt < max_v) ? cnt + CNT_MAX_W'(1) : cnt;
    end
    return (cnt != '0) ? cnt - CNT_MAX_W'(1) : cnt;
  endfunction

  // 32-bit event counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] stat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_pht.sv
// Pattern history table: 2^IDX_W saturating counters of CNT_W bits.
// One combinational read port (the counter MSB is the prediction) and one
// synchronous saturating update port. A read and a write to the same entry
// in the same cycle return the old value; there is no write-to-read bypass.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = DEF_IDX_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             wr_valid_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int unsigned      DEPTH   = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_rst(CNT_W));

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] wr_cnt_d;

  // Prediction is the MSB of the addressed counter.
  assign rd_taken_o = cnt_q[rd_idx_i][CNT_W-1];

  // Saturated next value for the entry being trained.
  always_comb begin
    wr_cnt_d = CNT_W'(sat_step(CNT_MAX_W'(cnt_q[wr_idx_i]), wr_taken_i, CNT_W));
  end

  // Counter array: reset to weakly taken, otherwise train one entry per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_RST;
      end
    end else if (wr_valid_i) begin
      cnt_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Branch direction predictor beside the IF stage.
// Predicts combinationally from the fetch PC and is trained when a branch
// resolves in EX. Keeps saturating resolved-branch and mispredict counters.
//
// Build option: define BP_GSHARE_EN to XOR the low HIST_W bits of the table
// index with a non-speculative global history register (gshare). Without
// it the predictor is bimodal: the index is the word-aligned PC bits only
// and no history register exists (HIST_W is then unused).
//
// Update interface: upd_valid is a plain valid with no back-pressure. Every
// cycle with upd_valid=1 is exactly one resolved branch and is always
// consumed at the next clock edge; upd_idx/upd_taken/upd_pred are ignored
// when upd_valid=0. Reset overrides an update in the same cycle.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int unsigned PC_W   = DEF_PC_W,
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned HIST_W = DEF_HIST_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred
);

  logic [IDX_W-1:0] base_idx;
  logic [31:0]      stat_branches_q, stat_branches_d;
  logic [31:0]      stat_mispred_q,  stat_mispred_d;
  logic             unused_pc_bits;

  // Instructions are word aligned, so PC[1:0] carry no information.
  assign base_idx       = pred_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0]  ghr_ext;

  // History zero-extended to the index width so only the low HIST_W bits hash.
  always_comb begin
    ghr_ext               = '0;
    ghr_ext[HIST_W-1:0]   = ghr_q;
  end

  assign pred_idx = base_idx ^ ghr_ext;

  // Shift the resolved outcome into the history; it never moves speculatively.
  if (HIST_W == 1) begin : g_hist_one
    always_comb begin
      ghr_d = ghr_q;
      if (upd_valid) begin
        ghr_d[0] = upd_taken;
      end
    end
  end else begin : g_hist_multi
    always_comb begin
      ghr_d = ghr_q;
      if (upd_valid) begin
        ghr_d = {ghr_q[HIST_W-2:0], upd_taken};
      end
    end
  end

  // Global history register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  localparam int unsigned UNUSED_HIST_W = HIST_W;

  assign pred_idx = base_idx;
`endif

  bp_pht #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_pht (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (pred_idx),
    .rd_taken_o (pred_taken),
    .wr_valid_i (upd_valid),
    .wr_idx_i   (upd_idx),
    .wr_taken_i (upd_taken)
  );

  // Next values of the performance counters; both stick at all-ones.
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (upd_valid) begin
      stat_branches_d = stat_inc(stat_branches_q);
      if (upd_pred != upd_taken) begin
        stat_mispred_d = stat_inc(stat_mispred_q);
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench for branch_predictor_gshare (default parameters).
// Works in both builds: the reference model switches to gshare indexing
// when BP_GSHARE_EN is defined.
module tb_branch_predictor_gshare;

  localparam int PC_W   = 32;
  localparam int IDX_W  = 6;
  localparam int HIST_W = 6;
  localparam int CNT_W  = 2;
  localparam int TBL    = 1 << IDX_W;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int CHALF  = 1 << (CNT_W - 1);
  localparam longint unsigned STAT_MAX = 64'hFFFF_FFFF;
`ifdef BP_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [PC_W-1:0]  pred_pc = '0;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic             upd_taken = 1'b0;
  logic             upd_pred = 1'b0;
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispred;

  always #5 clk = ~clk;

  branch_predictor_gshare #(
    .PC_W   (PC_W),
    .IDX_W  (IDX_W),
    .HIST_W (HIST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_idx      (pred_idx),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .upd_pred      (upd_pred),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int unsigned     m_cnt [TBL];
  int unsigned     m_ghr;
  longint unsigned m_br;
  longint unsigned m_mp;

  function automatic int unsigned model_idx(input logic [31:0] pc);
    int unsigned b;
    b = (pc / 4) % TBL;
    return GSHARE ? ((b ^ m_ghr) % TBL) : b;
  endfunction

  function automatic bit model_taken(input logic [31:0] pc);
    return m_cnt[model_idx(pc)] >= CHALF;
  endfunction

  // A PC whose prediction lands on table entry idx under the current history.
  function automatic logic [31:0] pc_for_idx(input int unsigned idx);
    int unsigned e;
    e = GSHARE ? ((idx ^ m_ghr) % TBL) : idx;
    return 32'(e * 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TBL; i++) m_cnt[i] = CHALF;
    m_ghr = 0;
    m_br  = 0;
    m_mp  = 0;
  endtask

  task automatic model_update(input int unsigned idx, input bit t, input bit p);
    if (t) m_cnt[idx] = (m_cnt[idx] < CMAX) ? m_cnt[idx] + 1 : m_cnt[idx];
    else   m_cnt[idx] = (m_cnt[idx] > 0)    ? m_cnt[idx] - 1 : 0;
    m_ghr = ((m_ghr * 2) + t) % (1 << HIST_W);
    if (m_br < STAT_MAX) m_br = m_br + 1;
    if (p != t && m_mp < STAT_MAX) m_mp = m_mp + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] pc, input bit uv, input int unsigned uidx,
                       input bit ut, input bit up);
    pred_pc   = pc;
    upd_valid = uv;
    upd_idx   = IDX_W'(uidx);
    upd_taken = ut;
    upd_pred  = up;
  endtask

  // Advance one clock edge, mirroring the edge into the model.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else if (upd_valid) model_update(upd_idx, upd_taken, upd_pred);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(32'h0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] pcs [3];
    int          exp_idx [3];
    pcs     = '{32'h0, 32'h4, 32'hFC};
    exp_idx = '{0, 1, 63};
    reset = 1'b1;
    drive(32'h0, 1'b1, 3, 1'b0, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    drive(32'h0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pred_pc = pcs[i];
      @(negedge clk);
      n_tests++;
      if (pred_taken !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_taken pc=%h got %b exp 1", pcs[i], pred_taken);
      end
      n_tests++;
      if (pred_idx !== IDX_W'(exp_idx[i])) begin
        n_fail++;
        $display("FAIL reset_idx pc=%h got %0d exp %0d", pcs[i], pred_idx, exp_idx[i]);
      end
    end
    n_tests++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_branches, stat_mispred);
    end
    tick();
  endtask

  task automatic test_saturation();
    bit outc [5];
    bit expp [5];
    outc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    expp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(pc_for_idx(5), 1'b1, 5, outc[i], 1'b1);
      tick();
      drive(pc_for_idx(5), 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (pred_taken !== expp[i] || pred_idx !== IDX_W'(5)) begin
        n_fail++;
        $display("FAIL saturation step=%0d got taken=%b idx=%0d exp taken=%b idx=5",
                 i, pred_taken, pred_idx, expp[i]);
      end
      tick();
    end
  endtask

  task automatic test_history();
    bit outc [3];
    outc = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 1'b1, 10, outc[i], outc[i]);
      tick();
    end
    drive(32'h14, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (pred_idx !== IDX_W'(GSHARE ? 3 : 5) || pred_taken !== model_taken(32'h14)) begin
      n_fail++;
      $display("FAIL history_idx got idx=%0d taken=%b exp idx=%0d taken=%b",
               pred_idx, pred_taken, GSHARE ? 3 : 5, model_taken(32'h14));
    end
    pred_pc = 32'h0;
    @(negedge clk);
    n_tests++;
    if (pred_idx !== IDX_W'(GSHARE ? 6 : 0)) begin
      n_fail++;
      $display("FAIL history_ghr got idx=%0d exp %0d", pred_idx, GSHARE ? 6 : 0);
    end
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    drive(32'h1C, 1'b1, 7, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++;
    if (pred_taken !== 1'b1 || pred_idx !== IDX_W'(7)) begin
      n_fail++;
      $display("FAIL hazard_same_cycle got taken=%b idx=%0d exp taken=1 idx=7",
               pred_taken, pred_idx);
    end
    tick();
    drive(32'h1C, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (pred_taken !== 1'b0 || pred_idx !== IDX_W'(7)) begin
      n_fail++;
      $display("FAIL hazard_next_cycle got taken=%b idx=%0d exp taken=0 idx=7",
               pred_taken, pred_idx);
    end
    tick();
  endtask

  task automatic test_stats();
    bit t;
    bit p;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      t = 1'($urandom_range(0, 1));
      p = (i == 2 || i == 5 || i == 8) ? ~t : t;
      drive($urandom, 1'b1, $urandom_range(0, TBL - 1), t, p);
      tick();
    end
    drive(32'h0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (stat_branches !== 32'd10 || stat_mispred !== 32'd3) begin
      n_fail++;
      $display("FAIL stats_count got %0d/%0d exp 10/3", stat_branches, stat_mispred);
    end
    // Preload near the ceiling and confirm the counters stick at all-ones.
    force dut.stat_branches_q = 32'hFFFF_FFFF;
    force dut.stat_mispred_q  = 32'hFFFF_FFFE;
    #1;
    release dut.stat_branches_q;
    release dut.stat_mispred_q;
    m_br = STAT_MAX;
    m_mp = STAT_MAX - 1;
    for (int i = 0; i < 2; i++) begin
      drive(32'h0, 1'b1, 4, 1'b1, 1'b0);
      tick();
    end
    drive(32'h0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (stat_branches !== 32'hFFFF_FFFF || stat_mispred !== 32'(m_mp)) begin
      n_fail++;
      $display("FAIL stats_saturate got %h/%h exp ffffffff/%h",
               stat_branches, stat_mispred, 32'(m_mp));
    end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(32'h0, 1'b1, 2, 1'b0, 1'b0);
    tick();
    drive(32'h0, 1'b1, 9, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    drive(32'h8, 1'b1, 2, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    drive(32'h8, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (pred_taken !== 1'b1 || pred_idx !== IDX_W'(2)) begin
      n_fail++;
      $display("FAIL mid_reset_pred got taken=%b idx=%0d exp taken=1 idx=2",
               pred_taken, pred_idx);
    end
    n_tests++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_stats got %0d/%0d exp 0/0", stat_branches, stat_mispred);
    end
    // Counter must be exactly weakly taken: one not-taken flips it.
    drive(32'h8, 1'b1, 2, 1'b0, 1'b0);
    tick();
    drive(32'h8, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_counter got taken=%b exp 0", pred_taken);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int unsigned uidx;
    bit          uv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pc   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7) * 4);
      uidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, TBL - 1) : $urandom_range(0, 7);
      uv   = ($urandom_range(0, 3) != 0);
      drive(pc, uv, uidx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      n_tests++;
      if (pred_idx !== IDX_W'(model_idx(pc)) || pred_taken !== model_taken(pc)) begin
        n_fail++;
        $display("FAIL random_pred i=%0d pc=%h got idx=%0d taken=%b exp idx=%0d taken=%b",
                 i, pc, pred_idx, pred_taken, model_idx(pc), model_taken(pc));
      end
      tick();
    end
    drive(32'h0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (stat_branches !== 32'(m_br) || stat_mispred !== 32'(m_mp)) begin
      n_fail++;
      $display("FAIL random_stats got %0d/%0d exp %0d/%0d",
               stat_branches, stat_mispred, m_br, m_mp);
    end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_saturation();
    test_history();
    test_hazard();
    test_stats();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
